// File: rtl/parity_word_serializer.sv
// Purpose: serializes 96-bit parity words onto the byte stream and flags the final byte of each 11-word frame.
// Latency: first byte of a word accepted into an empty buffer appears the cycle after acceptance.
// Backpressure: i_output_ready stalls the byte stream; o_input_ready is registered and low while two words are buffered.
// Build option: define PARITY_SER_MSB_FIRST_EN to emit each word most-significant byte first (default is LSB-first).
module parity_word_serializer #(
    parameter int IN_WIDTH        = 96,  // must be an integer multiple of OUT_WIDTH
    parameter int OUT_WIDTH       = 8,
    parameter int WORDS_PER_FRAME = 11
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic [IN_WIDTH-1:0]  i_input_data,
    input  logic                 i_input_valid,
    output logic                 o_input_ready,
    output logic [OUT_WIDTH-1:0] o_output_data,
    output logic                 o_output_valid,
    output logic                 o_output_last,
    input  logic                 i_output_ready
);
    localparam int BYTES_PER_WORD = IN_WIDTH / OUT_WIDTH;
    localparam int BIDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int WIDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [BIDX_W-1:0] BYTE_MAX = BIDX_W'(BYTES_PER_WORD - 1);
    localparam logic [WIDX_W-1:0] WORD_MAX = WIDX_W'(WORDS_PER_FRAME - 1);

    // Two-entry word buffer; head is the word currently being serialized.
    logic [IN_WIDTH-1:0] word_buf [2];
    logic                head_ptr;
    logic                tail_ptr;
    logic [1:0]          count;
    logic [1:0]          count_nxt;

    // Position within the current word and within the frame.
    logic [BIDX_W-1:0]   byte_idx;
    logic [WIDX_W-1:0]   word_idx;
    logic [BIDX_W-1:0]   lane;

    logic                push;
    logic                byte_xfer;
    logic                byte_at_end;
    logic                word_pop;

    // Handshake decode and next buffer occupancy.
    always_comb begin
        o_output_valid = (count != 2'd0);
        push           = i_input_valid && o_input_ready;
        byte_xfer      = o_output_valid && i_output_ready;
        byte_at_end    = (byte_idx == BYTE_MAX);
        word_pop       = byte_xfer && byte_at_end;
        count_nxt      = count;
        if (push && !word_pop) begin
            count_nxt = count + 2'd1;
        end else if (!push && word_pop) begin
            count_nxt = count - 2'd1;
        end
    end

    // Word storage: write the tail entry when a word is accepted; cleared on reset so data never goes X.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            word_buf[0] <= '0;
            word_buf[1] <= '0;
        end else if (push) begin
            word_buf[tail_ptr] <= i_input_data;
        end
    end

    // Buffer pointers, occupancy and the registered input-ready (reflects occupancy after this edge).
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            head_ptr      <= 1'b0;
            tail_ptr      <= 1'b0;
            count         <= 2'd0;
            o_input_ready <= 1'b0;
        end else begin
            if (push) begin
                tail_ptr <= ~tail_ptr;
            end
            if (word_pop) begin
                head_ptr <= ~head_ptr;
            end
            count         <= count_nxt;
            o_input_ready <= (count_nxt != 2'd2);
        end
    end

    // Byte and word position counters advance only on accepted bytes.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            byte_idx <= '0;
            word_idx <= '0;
        end else if (byte_xfer) begin
            if (byte_at_end) begin
                byte_idx <= '0;
                word_idx <= (word_idx == WORD_MAX) ? '0 : word_idx + WIDX_W'(1);
            end else begin
                byte_idx <= byte_idx + BIDX_W'(1);
            end
        end
    end

    // Byte lane select from the head word and end-of-frame flag.
    always_comb begin
`ifdef PARITY_SER_MSB_FIRST_EN
        lane = BYTE_MAX - byte_idx;
`else
        lane = byte_idx;
`endif
        o_output_data = word_buf[head_ptr][lane*OUT_WIDTH +: OUT_WIDTH];
        o_output_last = o_output_valid && byte_at_end && (word_idx == WORD_MAX);
    end

endmodule

// File: doc/parity_word_serializer.md
Name: parity_word_serializer

Overview:
- Reverse-direction partner of the sparse multiply-by-A stage: accepts the 11 x 96-bit parity words that stage produces per frame and serializes them back onto the 8-bit byte stream.
- Sits between the parity stage output and the byte-wide packet assembler. Flags the final byte of each 11-word frame.
- Two-entry word buffer so the next word can be accepted while the current one drains.

Parameters:
- IN_WIDTH, 96, parity word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, output byte width.
- WORDS_PER_FRAME, 11, parity words per frame.
- Derived (localparam, not overridable): BYTES_PER_WORD = IN_WIDTH/OUT_WIDTH (12); bytes per frame = 132.

Ports:
- i_clock  in  1  clock, all logic on rising edge.
- i_reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- i_input_data  in  IN_WIDTH  parity word.
- i_input_valid  in  1  upstream word valid.
- o_input_ready  out  1  word buffer can accept.
- o_output_data  out  OUT_WIDTH  current byte.
- o_output_valid  out  1  byte valid.
- o_output_last  out  1  final byte of frame, qualified by o_output_valid.
- i_output_ready  in  1  downstream accepts byte.

Behaviour:
- Reset (i_reset_n low at a rising edge): buffer count=0, byte_idx=0, word_idx=0, all outputs 0 (o_input_ready=0 while in reset). Reset mid-frame discards buffered words and partial frame; the next accepted word is word 0 of a new frame.
- Input handshake: a word is written when i_input_valid && o_input_ready at a rising edge.
  - o_input_ready = registered (count < 2). There is no combinational path from i_output_ready to o_input_ready.
  - When count==2, no push occurs even if a pop happens the same cycle. Ready rises the following cycle.
- Buffer: 2-entry FIFO (head/tail pointers plus count). Push and pop in the same cycle with count==1 leaves count=1.
- Output: o_output_valid = (count != 0).
  - o_output_data = head word bits [byte_idx*OUT_WIDTH +: OUT_WIDTH], so bits [7:0] go out first (LSB-first).
  - Data and last are held stable while valid && !i_output_ready.
- Byte handshake: on i_output_valid && i_output_ready, byte_idx increments.
  - At byte_idx == BYTES_PER_WORD-1, byte_idx wraps to 0, the head word pops, and word_idx increments.
  - word_idx wraps from WORDS_PER_FRAME-1 to 0.
- o_output_last = o_output_valid && byte_idx==BYTES_PER_WORD-1 && word_idx==WORDS_PER_FRAME-1.
- Latency: a word accepted at edge N presents its first byte in the cycle after edge N when the buffer was empty.
- Throughput: 1 byte/cycle sustained with continuous i_output_ready. Upstream sees ready for 1 in 12 cycles at steady state.
- Empty buffer: valid=0, byte_idx held. i_output_ready with no valid is ignored.
- Data values are don't-care while valid=0, but must be driven from buffer regs; no X after reset.

Optional Feature:
- Macro: PARITY_SER_MSB_FIRST_EN.
- Defined: byte order is reversed within each word. First byte = bits [IN_WIDTH-1 -: OUT_WIDTH]; last byte = bits [7:0]. Frame/last timing is unchanged.
- Undefined: LSB-first as above.

Test Plan:
- Idle: reset, i_input_valid=0, i_output_ready=1 for 100 cycles -> o_output_valid and o_output_last stay 0; o_input_ready=1 after reset releases.
- Single word: push 96'h0B0A09080706050403020100, ready=1 -> bytes 0x00,0x01,...,0x0B on 12 consecutive cycles, o_output_last=0 throughout. With PARITY_SER_MSB_FIRST_EN the sequence is 0x0B down to 0x00.
- Full frame: 11 words of all-ones pushed as fast as ready allows, i_output_ready=1 -> exactly 132 bytes of 0xFF, o_output_last high only on byte 132; upstream accepts all 11 words.
- Backpressure: i_output_ready pattern 1,0,0,1 repeating during a frame of words n*0x0101..01 -> no byte lost or duplicated; data/last stable while stalled; o_input_ready=0 whenever 2 words are buffered.
- Back-to-back frames: 22 words streamed -> o_output_last on bytes 132 and 264 only; word_idx wraps to 0 between frames.
- Reset mid-frame: assert i_reset_n=0 for 1 cycle after 50 bytes output -> next cycle valid=0, count=0. A fresh 11-word frame then yields 132 bytes with last on byte 132 after restart.
